// File: rtl/pipe_agent_pkg.sv
// Shared types and constants for the MAC-side PIPE agent blocks.
package pipe_agent_pkg;

   typedef logic [3:0] pipe_width_t;

   typedef enum logic [3:0] {
      PWR_P0  = 4'd0,
      PWR_P0S = 4'd1,
      PWR_P1  = 4'd2,
      PWR_P2  = 4'd3
   } pipe_power_e;

   typedef enum logic [1:0] {
      OP_POWER  = 2'd0,
      OP_RATE   = 2'd1,
      OP_DETECT = 2'd2,
      OP_RSVD   = 2'd3
   } pipe_cmd_op_e;

   typedef enum logic [1:0] {
      RSP_OK      = 2'd0,
      RSP_TIMEOUT = 2'd1,
      RSP_ILLEGAL = 2'd2
   } pipe_rsp_code_e;

   typedef enum logic [2:0] {
      ST_RESET_WAIT  = 3'd0,
      ST_IDLE        = 3'd1,
      ST_DRIVE       = 3'd2,
      ST_WAIT_STATUS = 3'd3,
      ST_RESP        = 3'd4
   } pipe_seq_state_e;

   localparam logic [2:0] RX_STATUS_DETECTED = 3'b011;

endpackage

// File: rtl/pipe_ctrl_timer.sv
// Loadable down-counter for the PIPE sequencer's phy_status timeout.
// Expiry is flagged while counting is enabled and the count has reached zero.
module pipe_ctrl_timer #(
   parameter int unsigned W = 11
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         expired_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: load has priority, counting stops at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = dec_i && (cnt_q == '0);

endmodule

// File: rtl/pipe_ctrl_seq.sv
// MAC-side PIPE control sequencer: power, rate and receiver-detect commands.
// Define PIPE_CTRL_TIMEOUT_EN to add the phy_status timeout (pipe_ctrl_timer).
module pipe_ctrl_seq
   import pipe_agent_pkg::*;
#(
   parameter int unsigned MAX_RATE       = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_op,
   input  logic [3:0] req_arg,
   output logic       rsp_valid,
   output logic [1:0] rsp_code,
   output logic       rsp_detected,
   input  logic       phy_status,
   input  logic [2:0] rx_status,
   output logic [3:0] power_down,
   output logic [3:0] rate,
   output logic       tx_detect_rx
);

   localparam pipe_width_t MAX_RATE_W = pipe_width_t'(MAX_RATE);

   pipe_seq_state_e state_q, state_d;
   pipe_cmd_op_e    op_q, op_d, op_s;
   pipe_width_t     pd_q, pd_d, rate_q, rate_d;
   pipe_rsp_code_e  code_q, code_d;
   logic            txd_q, txd_d, det_q, det_d;
   logic            rsp_valid_q, req_ready_q;
   logic            illegal_s, noop_s, timer_load_s, timer_expired_s;

   // Command classification against the PIPE values currently driven.
   always_comb begin
      op_s      = pipe_cmd_op_e'(req_op);
      illegal_s = 1'b0;
      noop_s    = 1'b0;
      case (op_s)
         OP_POWER: begin
            illegal_s = (req_arg > 4'd3);
            noop_s    = (req_arg == pd_q);
         end
         OP_RATE: begin
            illegal_s = (req_arg > MAX_RATE_W) || ((pd_q != PWR_P0) && (pd_q != PWR_P1));
            noop_s    = (req_arg == rate_q);
         end
         OP_DETECT: begin
            illegal_s = (pd_q != PWR_P1);
            noop_s    = 1'b0;
         end
         default: begin
            illegal_s = 1'b1;
            noop_s    = 1'b0;
         end
      endcase
   end

   // Sequencer next state; PIPE outputs change on the accept edge so they are visible in DRIVE.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      pd_d         = pd_q;
      rate_d       = rate_q;
      txd_d        = txd_q;
      code_d       = code_q;
      det_d        = det_q;
      timer_load_s = 1'b0;
      case (state_q)
         ST_RESET_WAIT: begin
            if (!phy_status) state_d = ST_IDLE;
            else             state_d = ST_RESET_WAIT;
         end
         ST_IDLE: begin
            if (req_valid) begin
               op_d = op_s;
               if (illegal_s || noop_s) begin
                  state_d = ST_RESP;
                  code_d  = illegal_s ? RSP_ILLEGAL : RSP_OK;
                  det_d   = 1'b0;
               end else begin
                  state_d = ST_DRIVE;
                  case (op_s)
                     OP_POWER:  pd_d   = req_arg;
                     OP_RATE:   rate_d = req_arg;
                     OP_DETECT: txd_d  = 1'b1;
                     default:   txd_d  = txd_q;
                  endcase
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            state_d      = ST_WAIT_STATUS;
            timer_load_s = 1'b1;
         end
         ST_WAIT_STATUS: begin
            // A status on the expiry cycle still completes OK.
            if (phy_status) begin
               state_d = ST_RESP;
               code_d  = RSP_OK;
               det_d   = (op_q == OP_DETECT) && (rx_status == RX_STATUS_DETECTED);
               txd_d   = 1'b0;
            end else if (timer_expired_s) begin
               state_d = ST_RESP;
               code_d  = RSP_TIMEOUT;
               det_d   = 1'b0;
               txd_d   = 1'b0;
            end else begin
               state_d = ST_WAIT_STATUS;
            end
         end
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_RESET_WAIT;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_RESET_WAIT;
         op_q        <= OP_POWER;
         pd_q        <= PWR_P1;
         rate_q      <= 4'd0;
         txd_q       <= 1'b0;
         code_q      <= RSP_OK;
         det_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         req_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         pd_q        <= pd_d;
         rate_q      <= rate_d;
         txd_q       <= txd_d;
         code_q      <= code_d;
         det_q       <= det_d;
         rsp_valid_q <= (state_d == ST_RESP);
         req_ready_q <= (state_d == ST_IDLE);
      end
   end

`ifdef PIPE_CTRL_TIMEOUT_EN
   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   pipe_ctrl_timer #(.W(TMR_W)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (timer_load_s),
      .load_val_i (TMR_W'(TIMEOUT_CYCLES)),
      .dec_i      (state_q == ST_WAIT_STATUS),
      .expired_o  (timer_expired_s)
   );
`else
   // Without the timer the timeout setting and load strobe have no effect.
   logic unused_timeout_s;
   assign unused_timeout_s = timer_load_s ^ (TIMEOUT_CYCLES == 32'd0);
   assign timer_expired_s  = 1'b0;
`endif

   assign req_ready    = req_ready_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_code     = code_q;
   assign rsp_detected = det_q;
   assign power_down   = pd_q;
   assign rate         = rate_q;
   assign tx_detect_rx = txd_q;

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Self-checking bench for pipe_ctrl_seq: scoreboard of expected responses plus direct PIPE output checks.
// Timeout scenarios run only when PIPE_CTRL_TIMEOUT_EN is defined.
module tb_pipe_ctrl_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [3:0] req_arg;
   logic       rsp_valid;
   logic [1:0] rsp_code;
   logic       rsp_detected;
   logic       phy_status;
   logic [2:0] rx_status;
   logic [3:0] power_down;
   logic [3:0] rate;
   logic       tx_detect_rx;

   int n_checks = 0;
   int n_fail   = 0;
   logic [2:0] exp_q[$];   // {code, detected}

   localparam logic [1:0] C_OK = 2'd0, C_TMO = 2'd1, C_ILL = 2'd2;
   localparam logic [1:0] OPW = 2'd0, ORT = 2'd1, ODT = 2'd2, ORS = 2'd3;

   pipe_ctrl_seq #(.MAX_RATE(4), .TIMEOUT_CYCLES(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_arg      (req_arg),
      .rsp_valid    (rsp_valid),
      .rsp_code     (rsp_code),
      .rsp_detected (rsp_detected),
      .phy_status   (phy_status),
      .rx_status    (rx_status),
      .power_down   (power_down),
      .rate         (rate),
      .tx_detect_rx (tx_detect_rx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Response monitor: every rsp_valid pulse must match the oldest expected response.
   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         check("rsp_vs_ready", 32'(req_ready), 32'd0);
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            logic [2:0] e;
            e = exp_q.pop_front();
            check("rsp_code", 32'(rsp_code), 32'(e[2:1]));
            check("rsp_detected", 32'(rsp_detected), 32'(e[0]));
         end
      end
   end

   // Offer one command; returns at the negedge of the cycle after accept.
   task automatic issue(input logic [1:0] op, input logic [3:0] arg,
                        input logic [1:0] code, input logic det, input bit immediate);
      int n;
      n = 0;
      @(negedge clk);
      while (req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_arg   = arg;
      exp_q.push_back({code, det});
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("ready_drop", 32'(req_ready), 32'd0);
      check(immediate ? "rsp_immediate" : "rsp_not_yet", 32'(rsp_valid), immediate ? 32'd1 : 32'd0);
      if (immediate) begin
         @(negedge clk);
         check("ready_return", 32'(req_ready), 32'd1);
      end
   endtask

   // Pulse phy_status after 'delay' cycles and check the completion timing.
   task automatic pulse(input int delay, input logic [2:0] rx, input logic txd_before);
      repeat (delay) @(posedge clk);
      #1;
      check("txd_before_status", 32'(tx_detect_rx), 32'(txd_before));
      phy_status = 1'b1;
      rx_status  = rx;
      @(posedge clk);
      #1 phy_status = 1'b0;
      rx_status = 3'd0;
      @(negedge clk);
      check("rsp_latency", 32'(rsp_valid), 32'd1);
      check("txd_after_status", 32'(tx_detect_rx), 32'd0);
      check("ready_during_rsp", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("ready_after_rsp", 32'(req_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      reset      = 1'b0;
      req_valid  = 1'b0;
      req_op     = 2'd0;
      req_arg    = 4'd0;
      phy_status = 1'b1;
      rx_status  = 3'd0;

      // Reset values, then release with phy_status held high.
      @(negedge clk);
      check("rst_power_down", 32'(power_down), 32'd2);
      check("rst_rate", 32'(rate), 32'd0);
      check("rst_txd", 32'(tx_detect_rx), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_code", 32'(rsp_code), 32'd0);
      check("rst_rsp_det", 32'(rsp_detected), 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("ready_while_phy_busy", 32'(req_ready), 32'd0);
      end
      @(posedge clk);
      #1 phy_status = 1'b0;
      @(negedge clk);
      check("ready_at_phy_fall", 32'(req_ready), 32'd0);
      n = 0;
      while (req_ready !== 1'b1 && n < 5) begin
         @(negedge clk);
         n++;
      end
      check("ready_rise_window", 32'((n >= 1) && (n <= 2)), 32'd1);
      check("idle_power_down", 32'(power_down), 32'd2);
      check("idle_rate", 32'(rate), 32'd0);

      // POWER P0 from P1.
      issue(OPW, 4'd0, C_OK, 1'b0, 1'b0);
      check("p0_power_down", 32'(power_down), 32'd0);
      pulse(5, 3'd0, 1'b0);

      // Illegal: rate above MAX_RATE, DETECT outside P1.
      issue(ORT, 4'd5, C_ILL, 1'b0, 1'b1);
      check("ill_rate_kept", 32'(rate), 32'd0);
      issue(ODT, 4'd0, C_ILL, 1'b0, 1'b1);
      check("ill_det_txd", 32'(tx_detect_rx), 32'd0);
      check("ill_det_pd", 32'(power_down), 32'd0);

      // Legal rate change in P0, then the same rate as a no-op.
      issue(ORT, 4'd2, C_OK, 1'b0, 1'b0);
      check("rate2", 32'(rate), 32'd2);
      pulse(3, 3'd0, 1'b0);
      issue(ORT, 4'd2, C_OK, 1'b0, 1'b1);
      check("noop_rate", 32'(rate), 32'd2);

      // Back to P1, then receiver detect with and without a receiver.
      issue(OPW, 4'd2, C_OK, 1'b0, 1'b0);
      check("p1_power_down", 32'(power_down), 32'd2);
      pulse(2, 3'd0, 1'b0);
      issue(ODT, 4'd0, C_OK, 1'b1, 1'b0);
      check("det_txd_n1", 32'(tx_detect_rx), 32'd1);
      pulse(4, 3'b011, 1'b1);
      issue(ODT, 4'd9, C_OK, 1'b0, 1'b0);
      check("det2_txd_n1", 32'(tx_detect_rx), 32'd1);
      pulse(1, 3'b000, 1'b1);

      // More illegal cases: bad power state, reserved op, rate change in P2.
      issue(OPW, 4'd5, C_ILL, 1'b0, 1'b1);
      check("ill_pd_kept", 32'(power_down), 32'd2);
      issue(ORS, 4'd0, C_ILL, 1'b0, 1'b1);
      issue(OPW, 4'd3, C_OK, 1'b0, 1'b0);
      check("p2_power_down", 32'(power_down), 32'd3);
      pulse(2, 3'd0, 1'b0);
      issue(ORT, 4'd1, C_ILL, 1'b0, 1'b1);
      check("ill_p2_rate_kept", 32'(rate), 32'd2);
      issue(OPW, 4'd2, C_OK, 1'b0, 1'b0);
      pulse(1, 3'd0, 1'b0);

`ifdef PIPE_CTRL_TIMEOUT_EN
      // No status: TIMEOUT after 16 counted WAIT cycles, rate keeps the new value.
      issue(ORT, 4'd1, C_TMO, 1'b0, 1'b0);
      check("tmo_rate", 32'(rate), 32'd1);
      n = 0;
      while (rsp_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("tmo_latency", 32'(n), 32'd18);
      check("tmo_rate_kept", 32'(rate), 32'd1);
      // Status on the expiry cycle wins.
      issue(ORT, 4'd3, C_OK, 1'b0, 1'b0);
      repeat (17) @(posedge clk);
      #1 phy_status = 1'b1;
      @(posedge clk);
      #1 phy_status = 1'b0;
      @(negedge clk);
      check("tmo_tie_rsp", 32'(rsp_valid), 32'd1);
      check("tmo_tie_rate", 32'(rate), 32'd3);
`endif

      // Reset in the middle of a DETECT wait drops the command.
      issue(ODT, 4'd0, C_OK, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      check("pre_rst_txd", 32'(tx_detect_rx), 32'd1);
      phy_status = 1'b1;
      reset = 1'b0;
      #1;
      check("midrst_txd", 32'(tx_detect_rx), 32'd0);
      check("midrst_pd", 32'(power_down), 32'd2);
      check("midrst_rate", 32'(rate), 32'd0);
      check("midrst_ready", 32'(req_ready), 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_wait_ready", 32'(req_ready), 32'd0);
         check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      end
      phy_status = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_ready", 32'(req_ready), 32'd1);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
